// File: rtl/if_id_queue.sv
// if_id_queue: elastic IF/ID pipeline boundary.
// A DEPTH-entry circular buffer of {PC, PC+4, instruction} decouples fetch from
// decode. Flush empties the queue in one cycle for taken branches and jumps.
// Optional feature macro: IFID_DECODE_FIELDS_EN adds the decoded field outputs
// (register numbers, 16-bit offset, 26-bit jump target) sliced from the head.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high (and Flush is low). InReady_IF depends only on Count, never on
// OutReady_ID. The head outputs stay stable while OutValid_ID is high and
// OutReady_ID is low.
module if_id_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       InValid_IF,
  output logic                       InReady_IF,
  input  logic [ADDR_W-1:0]          PC_IF,
  input  logic [ADDR_W-1:0]          PCAdderResult_IF,
  input  logic [DATA_W-1:0]          Instruction_IF,
  input  logic                       Flush,
  output logic                       OutValid_ID,
  input  logic                       OutReady_ID,
  output logic [ADDR_W-1:0]          PC_ID,
  output logic [ADDR_W-1:0]          PCAdderResult_ID,
  output logic [DATA_W-1:0]          Instruction_ID,
`ifdef IFID_DECODE_FIELDS_EN
  output logic [4:0]                 ReadReg1_ID,
  output logic [4:0]                 ReadReg2_ID,
  output logic [4:0]                 Rd_ID,
  output logic [15:0]                Offset_ID,
  output logic [25:0]                J_ID,
`endif
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [ADDR_W-1:0] pcadd_mem [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             push;
  logic             pop;

  assign InReady_IF  = (Count != CNT_W'(DEPTH));
  assign OutValid_ID = (Count != '0);
  assign push        = InValid_IF & InReady_IF & ~Flush;
  assign pop         = OutValid_ID & OutReady_ID & ~Flush;

  // Entry storage: written at wp on push; contents are never reset because
  // the head outputs are masked by Count.
  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem[wp]    <= PC_IF;
      pcadd_mem[wp] <= PCAdderResult_IF;
      instr_mem[wp] <= Instruction_IF;
    end
  end

  // Pointer and occupancy update with priority Reset > Flush > push/pop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wp    <= '0;
      rp    <= '0;
      Count <= '0;
    end else if (Flush) begin
      wp    <= '0;
      rp    <= '0;
      Count <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   Count <= Count + CNT_W'(1);
        2'b01:   Count <= Count - CNT_W'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Head read of entry rp, forced to zero (a NOP bubble) when empty.
  always_comb begin
    PC_ID            = '0;
    PCAdderResult_ID = '0;
    Instruction_ID   = '0;
    if (OutValid_ID) begin
      PC_ID            = pc_mem[rp];
      PCAdderResult_ID = pcadd_mem[rp];
      Instruction_ID   = instr_mem[rp];
    end
  end

`ifdef IFID_DECODE_FIELDS_EN
  // Decoded fields are slices of the masked head, so they read 0 when empty.
  always_comb begin
    ReadReg1_ID = Instruction_ID[25:21];
    ReadReg2_ID = Instruction_ID[20:16];
    Rd_ID       = Instruction_ID[15:11];
    Offset_ID   = Instruction_ID[15:0];
    J_ID        = Instruction_ID[25:0];
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a DEPTH=2 and a DEPTH=4 instance share one stimulus
// stream; each is checked every cycle against its own list-based model, plus
// literal expectations for the directed scenarios.
module tb_if_id_queue;

  logic        Clk;
  logic        Reset;
  logic        InValid_IF;
  logic [31:0] PC_IF;
  logic [31:0] PCAdderResult_IF;
  logic [31:0] Instruction_IF;
  logic        Flush;
  logic        OutReady_ID;

  logic        in_ready2, out_valid2;
  logic [31:0] pc2, pcadd2, instr2;
  logic [1:0]  count2;
  logic        in_ready4, out_valid4;
  logic [31:0] pc4, pcadd4, instr4;
  logic [2:0]  count4;
`ifdef IFID_DECODE_FIELDS_EN
  logic [4:0]  rr1_2, rr2_2, rd_2, rr1_4, rr2_4, rd_4;
  logic [15:0] off_2, off_4;
  logic [25:0] j_2, j_4;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Scoreboards: element 0 is the head; entries are {pc, pc+4, instr}.
  logic [95:0] exp_q2[$];
  logic [95:0] exp_q4[$];

  if_id_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .InValid_IF(InValid_IF), .InReady_IF(in_ready2),
    .PC_IF(PC_IF), .PCAdderResult_IF(PCAdderResult_IF), .Instruction_IF(Instruction_IF),
    .Flush(Flush), .OutValid_ID(out_valid2), .OutReady_ID(OutReady_ID),
    .PC_ID(pc2), .PCAdderResult_ID(pcadd2), .Instruction_ID(instr2),
`ifdef IFID_DECODE_FIELDS_EN
    .ReadReg1_ID(rr1_2), .ReadReg2_ID(rr2_2), .Rd_ID(rd_2), .Offset_ID(off_2), .J_ID(j_2),
`endif
    .Count(count2)
  );

  if_id_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .InValid_IF(InValid_IF), .InReady_IF(in_ready4),
    .PC_IF(PC_IF), .PCAdderResult_IF(PCAdderResult_IF), .Instruction_IF(Instruction_IF),
    .Flush(Flush), .OutValid_ID(out_valid4), .OutReady_ID(OutReady_ID),
    .PC_ID(pc4), .PCAdderResult_ID(pcadd4), .Instruction_ID(instr4),
`ifdef IFID_DECODE_FIELDS_EN
    .ReadReg1_ID(rr1_4), .ReadReg2_ID(rr2_4), .Rd_ID(rd_4), .Offset_ID(off_4), .J_ID(j_4),
`endif
    .Count(count4)
  );

  // Clock
  initial Clk = 0;
  always #5 Clk = ~Clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the same edge the DUTs sample their inputs.
  always @(posedge Clk) begin
    bit full2, full4, push2, push4, pop2, pop4;
    full2 = (exp_q2.size() == 2);
    full4 = (exp_q4.size() == 4);
    push2 = InValid_IF && !full2 && !Flush;
    push4 = InValid_IF && !full4 && !Flush;
    pop2  = (exp_q2.size() != 0) && OutReady_ID && !Flush;
    pop4  = (exp_q4.size() != 0) && OutReady_ID && !Flush;
    if (Reset || Flush) begin
      exp_q2.delete();
      exp_q4.delete();
    end else begin
      if (pop2) void'(exp_q2.pop_front());
      if (pop4) void'(exp_q4.pop_front());
      if (push2) exp_q2.push_back({PC_IF, PCAdderResult_IF, Instruction_IF});
      if (push4) exp_q4.push_back({PC_IF, PCAdderResult_IF, Instruction_IF});
    end
  end

  // Compare process: outputs versus model, mid-cycle.
  always @(negedge Clk) begin
    logic [95:0] h2, h4;
    if (chk_en) begin
      h2 = (exp_q2.size() != 0) ? exp_q2[0] : 96'd0;
      h4 = (exp_q4.size() != 0) ? exp_q4[0] : 96'd0;
      cmp("d2_count",  32'(count2), 32'(exp_q2.size()));
      cmp("d2_ovalid", 32'(out_valid2), 32'(exp_q2.size() != 0));
      cmp("d2_iready", 32'(in_ready2), 32'(exp_q2.size() != 2));
      cmp("d2_pc",     pc2,    h2[95:64]);
      cmp("d2_pcadd",  pcadd2, h2[63:32]);
      cmp("d2_instr",  instr2, h2[31:0]);
      cmp("d4_count",  32'(count4), 32'(exp_q4.size()));
      cmp("d4_ovalid", 32'(out_valid4), 32'(exp_q4.size() != 0));
      cmp("d4_iready", 32'(in_ready4), 32'(exp_q4.size() != 4));
      cmp("d4_pc",     pc4,    h4[95:64]);
      cmp("d4_pcadd",  pcadd4, h4[63:32]);
      cmp("d4_instr",  instr4, h4[31:0]);
`ifdef IFID_DECODE_FIELDS_EN
      cmp("d4_rr1", 32'(rr1_4), 32'(h4[25:21]));
      cmp("d4_rr2", 32'(rr2_4), 32'(h4[20:16]));
      cmp("d4_rd",  32'(rd_4),  32'(h4[15:11]));
      cmp("d4_off", 32'(off_4), 32'(h4[15:0]));
      cmp("d4_j",   32'(j_4),   32'(h4[25:0]));
      cmp("d2_j",   32'(j_2),   32'(h2[25:0]));
      cmp("d2_rd",  32'(rd_2) ^ 32'(rr1_2) ^ 32'(rr2_2),
          32'(h2[15:11]) ^ 32'(h2[25:21]) ^ 32'(h2[20:16]));
      cmp("d2_off", 32'(off_2), 32'(h2[15:0]));
`endif
    end
  end

  // Driver: present one cycle of inputs, wait for the edge, settle 1 time unit.
  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                      input bit rdy, input bit fl);
    InValid_IF       = v;
    PC_IF            = pc;
    PCAdderResult_IF = pc + 32'd4;
    Instruction_IF   = ins;
    OutReady_ID      = rdy;
    Flush            = fl;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1;
    InValid_IF = 0; PC_IF = 0; PCAdderResult_IF = 0; Instruction_IF = 0;
    Flush = 0; OutReady_ID = 0;
    @(posedge Clk); #1;
    chk_en = 1;
    step(0, 0, 0, 0, 0);
    Reset = 0;
    cmp("rst_count", 32'(count4), 32'd0);
    cmp("rst_iready", 32'(in_ready2), 32'd1);
    cmp("rst_ovalid", 32'(out_valid2), 32'd0);
    cmp("rst_instr", instr4, 32'd0);

    // Reset mid-operation after filling two entries.
    step(1, 32'h40, 32'hAAAA0001, 0, 0);
    step(1, 32'h44, 32'hAAAA0002, 0, 0);
    cmp("mid_count2", 32'(count2), 32'd2);
    Reset = 1;
    step(0, 0, 0, 0, 0);
    Reset = 0;
    cmp("mid_rst_count", 32'(count2), 32'd0);
    cmp("mid_rst_ovalid", 32'(out_valid4), 32'd0);
    cmp("mid_rst_iready", 32'(in_ready2), 32'd1);
    cmp("mid_rst_instr", instr2, 32'd0);

    // Streaming with decode always ready.
    for (int i = 0; i < 4; i++) begin
      step(1, 32'(i * 4), 32'h1000 + 32'(i), 1, 0);
      cmp("stream_pc", pc4, 32'(i * 4));
      cmp("stream_pcadd", pcadd4, 32'(i * 4 + 4));
      cmp("stream_count", 32'(count4), 32'd1);
    end
    step(0, 0, 0, 1, 0);
    cmp("stream_drain", 32'(count4), 32'd0);

    // Backpressure on the DEPTH=2 instance.
    step(1, 32'h100, 32'h2000, 0, 0);
    step(1, 32'h104, 32'h2001, 0, 0);
    cmp("bp_count", 32'(count2), 32'd2);
    cmp("bp_iready", 32'(in_ready2), 32'd0);
    step(1, 32'h108, 32'h2002, 0, 0);
    cmp("bp_hold_count", 32'(count2), 32'd2);
    cmp("bp_hold_head", pc2, 32'h100);
    step(1, 32'h108, 32'h2002, 1, 0);
    cmp("bp_head1", pc2, 32'h104);
    step(1, 32'h108, 32'h2002, 1, 0);
    cmp("bp_head2", pc2, 32'h108);
    step(0, 0, 0, 0, 1);

    // Flush with simultaneous push and pop at Count=1.
    step(1, 32'h200, 32'h3000, 0, 0);
    step(1, 32'h204, 32'h3001, 1, 1);
    cmp("fl_count", 32'(count4), 32'd0);
    cmp("fl_iready", 32'(in_ready2), 32'd1);
    step(1, 32'h208, 32'h3002, 0, 0);
    cmp("fl_next_head", pc4, 32'h208);
    cmp("fl_next_count", 32'(count2), 32'd1);
    step(0, 0, 0, 0, 1);

    // Field decode of add $8,$9,$10.
    step(1, 32'h300, 32'h012A4020, 0, 0);
    cmp("fld_instr", instr4, 32'h012A4020);
`ifdef IFID_DECODE_FIELDS_EN
    cmp("fld_rr1", 32'(rr1_4), 32'd9);
    cmp("fld_rr2", 32'(rr2_4), 32'd10);
    cmp("fld_rd",  32'(rd_4),  32'd8);
    cmp("fld_off", 32'(off_4), 32'h4020);
    cmp("fld_j",   32'(j_4),   32'h12A4020);
`endif
    step(0, 0, 0, 0, 1);
`ifdef IFID_DECODE_FIELDS_EN
    cmp("fld_empty_j", 32'(j_4), 32'd0);
`endif

    // Randomized traffic with varying rates and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 60), $urandom & 32'hFFFF_FFFC, $urandom,
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID pipeline boundary that replaces the single-entry IF/ID latch with a small elastic queue. Each entry holds a fetched instruction with its PC and PC+4. Fetch and decode are decoupled by a valid/ready handshake, so a decode stall no longer freezes fetch until the queue fills. The block sits between the PC adder / instruction memory and the decode/register-file stage, and supports a single-cycle flush for taken branches and jumps.

## Interface

Parameters:
- DATA_W, 32, instruction width in bits (≥32 when field decode is enabled).
- ADDR_W, 32, PC and PC+4 width in bits.
- DEPTH, 2, number of queue entries. Power of two, 2..8.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid_IF  in  1  fetch presents a valid entry.
- InReady_IF  out  1  queue can accept; equals (Count != DEPTH).
- PC_IF  in  ADDR_W  PC of the fetched instruction.
- PCAdderResult_IF  in  ADDR_W  PC+4 of the fetched instruction.
- Instruction_IF  in  DATA_W  fetched instruction word.
- Flush  in  1  discard all held entries and any same-cycle input.
- OutValid_ID  out  1  head entry is valid; equals (Count != 0).
- OutReady_ID  in  1  decode consumes the head this cycle.
- PC_ID  out  ADDR_W  head PC; 0 when empty.
- PCAdderResult_ID  out  ADDR_W  head PC+4; 0 when empty.
- Instruction_ID  out  DATA_W  head instruction; 0 (NOP) when empty.
- Count  out  $clog2(DEPTH+1)  number of held entries.
- ReadReg1_ID, ReadReg2_ID, Rd_ID  out  5 each  instr[25:21], [20:16], [15:11] of head (present only with IFID_DECODE_FIELDS_EN).
- Offset_ID  out  16  instr[15:0] of head (present only with IFID_DECODE_FIELDS_EN).
- J_ID  out  26  instr[25:0] of head (present only with IFID_DECODE_FIELDS_EN).

## Operation

- Storage is a circular buffer of DEPTH entries {PC, PC+4, instruction}, with write pointer wp, read pointer rp (log2(DEPTH) bits, wrap modulo DEPTH) and Count.
- push = InValid_IF & InReady_IF & ~Flush. Writes entry at wp, then wp+1.
- pop = OutValid_ID & OutReady_ID & ~Flush. Advances rp by 1.
- Count update: +1 on push only, −1 on pop only, unchanged on push&pop.
- Push and pop in the same cycle are legal at any Count in 1..DEPTH−1.
- When full, InReady_IF=0, so no push happens. There is no same-cycle bypass of a full queue.
- Flush: wp, rp and Count go to 0. Input offered in the same cycle is dropped and OutReady_ID is ignored. The flush acts even if the queue is already empty.
- Priority: Reset > Flush > push/pop.
- Head outputs are a combinational read of entry rp, masked to 0 when Count==0. Decode therefore sees a NOP bubble when empty, matching the old flush behaviour.
- InReady_IF depends only on Count. There is no combinational path from OutReady_ID to InReady_IF.
- Array contents are not reset. All outputs are defined by Count masking.

## Timing

- Reset (synchronous): next edge sets wp=rp=Count=0. Outputs then read OutValid_ID=0, InReady_IF=1, and all data and field outputs 0.
- Latency: an entry pushed at edge N is visible on the head outputs and OutValid_ID after edge N. That is one cycle, when the queue was empty.
- Throughput: one entry per cycle sustained with OutReady_ID held high.
- Flush asserted before edge N: after edge N, OutValid_ID=0 and InReady_IF=1. The first post-flush push can occur in cycle N+1.
- Stall (OutReady_ID=0): the head is held stable. Fetch continues until Count==DEPTH, then InReady_IF drops in the same cycle Count reaches DEPTH.
- Pointers wrap from DEPTH−1 to 0 with no bubble.

## Configuration

- IFID_DECODE_FIELDS_EN defined: the five field outputs exist. They are slices of the masked head instruction, so they are 0 when empty.
- Not defined: the field ports and their logic are omitted, and decode slices Instruction_ID itself. The queue behaviour is identical in both builds.

## Test plan

- Reset mid-operation: fill 2 entries, assert Reset for 1 cycle -> Count=0, OutValid_ID=0, InReady_IF=1, Instruction_ID=0 on the next cycle.
- Streaming: push PC=0x00,0x04,0x08,0x0C on consecutive cycles with OutReady_ID=1 -> head shows each PC one cycle after its push; Count stays 1; PCAdderResult_ID=PC+4.
- Backpressure with DEPTH=2: OutReady_ID=0, push 0x100,0x104 -> Count=2 and InReady_IF=0; a third offered 0x108 is not accepted. Release OutReady_ID -> order 0x100,0x104,0x108 with no loss.
- Flush with simultaneous push and pop at Count=1 -> Count=0 after the edge, and the offered entry is discarded. The next push appears as head one cycle later.
- Wrap-around with DEPTH=4: 10 pushes/pops at varying rates -> FIFO order preserved across pointer wrap; Count never exceeds 4.
- Fields (with macro): push 0x012A4020 (add $8,$9,$10) -> ReadReg1_ID=9, ReadReg2_ID=10, Rd_ID=8, Offset_ID=0x4020, J_ID=0x12A4020. All fields are 0 when empty.
